// File: rtl/aes_enc_core_param.sv
// aes_enc_core_param
//
// Iterative AES encryption core: one round per clock. The key size is set by KEY_BITS
// (128/192/256 giving NR = 10/12/14 rounds). Round keys are pre-expanded elsewhere and
// fetched combinationally through rk_idx/rk.
//
// Ports
//   clk        clock
//   rst        synchronous, active-low reset
//   in_valid   plaintext block offered
//   in_ready   core accepts a block this cycle (IDLE only)
//   text_in    plaintext, [127:120] = byte 0, column-major
//   rk_idx     index of the round key needed this cycle, 0..NR
//   rk         round key rk_idx, valid in the same cycle, [127:96] = word 4*rk_idx
//   out_valid  ciphertext available
//   out_ready  consumer accepts ciphertext
//   text_out   registered ciphertext, same byte order as text_in
//   busy       block in flight (RUN or FINAL)
//
// Optional build macro AES_ENC_DBG_EN adds:
//   dbg_state  live state register
//   dbg_round  current round counter (0 in IDLE)

module aes_enc_core_param #(
   parameter int unsigned KEY_BITS = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] text_in,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] text_out,
   output logic         busy
`ifdef AES_ENC_DBG_EN
   ,
   output logic [127:0] dbg_state,
   output logic [3:0]   dbg_round
`endif
);

   localparam int unsigned NR       = KEY_BITS / 32 + 6;
   localparam logic [3:0]  RndFinal = 4'(NR);
   localparam logic [3:0]  RndLast  = 4'(NR - 1);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_bad_key_bits
      $error("aes_enc_core_param: KEY_BITS must be 128, 192 or 256");
   end

   // Forward S-box, entry 0 in the top byte. Kept local so the file is self-contained.
   localparam logic [2047:0] SboxTbl = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {StIdle, StRun, StFinal} fsm_e;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] msb;
      msb = 11'd2047 - {b, 3'b000};
      return SboxTbl[msb -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = sbox(s[8*i +: 8]);
      end
      return r;
   endfunction

   // Byte (row, col) sits at index row + 4*col counted from the MSB end.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            r[127 - 8*(row + 4*col) -: 8] = s[127 - 8*(row + 4*((col + row) % 4)) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      for (int col = 0; col < 4; col++) begin
         r[127 - 32*col -: 32] = mix_col(s[127 - 32*col -: 32]);
      end
      return r;
   endfunction

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] state_q, state_d;
   logic         out_valid_q, out_valid_d;
   logic [127:0] text_out_q, text_out_d;

   logic [127:0] sb_state, sr_state, mc_state;
   logic         out_free;

   // One shared SubBytes/ShiftRows feeds both the full rounds and the final round.
   assign sb_state = sub_bytes(state_q);
   assign sr_state = shift_rows(sb_state);
   assign mc_state = mix_columns(sr_state);

   // Output register can take a new result if empty or being drained this cycle.
   assign out_free = !out_valid_q || out_ready;

   always_comb begin
      fsm_d       = fsm_q;
      rnd_d       = rnd_q;
      state_d     = state_q;
      out_valid_d = out_valid_q;
      text_out_d  = text_out_q;
      in_ready    = 1'b0;
      rk_idx      = 4'd0;
      busy        = 1'b0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (fsm_q)
         StIdle: begin
            // Gated by rst so the core never advertises readiness while held in reset.
            in_ready = rst;
            if (in_valid && rst) begin
               state_d = text_in ^ rk;
               rnd_d   = 4'd1;
               fsm_d   = StRun;
            end
         end
         StRun: begin
            busy    = 1'b1;
            rk_idx  = rnd_q;
            state_d = mc_state ^ rk;
            rnd_d   = rnd_q + 4'd1;
            if (rnd_q == RndLast) begin
               fsm_d = StFinal;
            end
         end
         StFinal: begin
            busy   = 1'b1;
            rk_idx = RndFinal;
            if (out_free) begin
               text_out_d  = sr_state ^ rk;
               out_valid_d = 1'b1;
               rnd_d       = 4'd0;
               fsm_d       = StIdle;
            end
         end
         default: begin
            fsm_d = StIdle;
            rnd_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_q       <= StIdle;
         rnd_q       <= 4'd0;
         state_q     <= '0;
         out_valid_q <= 1'b0;
         text_out_q  <= '0;
      end else begin
         fsm_q       <= fsm_d;
         rnd_q       <= rnd_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         text_out_q  <= text_out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign text_out  = text_out_q;

`ifdef AES_ENC_DBG_EN
   assign dbg_state = state_q;
   assign dbg_round = rnd_q;
`endif

endmodule

// File: tb/tb_aes_enc_core_param.sv
// tb_aes_enc_core_param
//
// Three cores (KEY_BITS 128/192/256) share clock and reset. Round keys come from a bench-side
// key schedule; expected ciphertexts (FIPS-197 constants or a byte-array reference model) are
// queued when a block is offered and compared when the core hands it over.

module tb_aes_enc_core_param;

   localparam int NDUT = 3;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] R1_C1 = 128'h89d810e8855ace682d1843d8cb128fe4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid  [NDUT];
   logic         in_ready  [NDUT];
   logic [127:0] text_in   [NDUT];
   logic [3:0]   rk_idx    [NDUT];
   logic [127:0] rk        [NDUT];
   logic         out_valid [NDUT];
   logic         out_ready [NDUT];
   logic [127:0] text_out  [NDUT];
   logic         busy      [NDUT];
`ifdef AES_ENC_DBG_EN
   logic [127:0] dbg_state [NDUT];
   logic [3:0]   dbg_round [NDUT];
`endif

   logic [127:0] rkeys [NDUT][16];
   logic [7:0]   sb_t  [256];
   logic [127:0] sbq0 [$];
   logic [127:0] sbq1 [$];
   logic [127:0] sbq2 [$];

   int   n_tests   = 0;
   int   n_fail    = 0;
   logic hold_pend = 1'b0;

   for (genvar g = 0; g < NDUT; g++) begin : gen_dut
      aes_enc_core_param #(
         .KEY_BITS(128 + 64 * g)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .text_in  (text_in[g]),
         .rk_idx   (rk_idx[g]),
         .rk       (rk[g]),
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .text_out (text_out[g]),
         .busy     (busy[g])
`ifdef AES_ENC_DBG_EN
         ,
         .dbg_state(dbg_state[g]),
         .dbg_round(dbg_round[g])
`endif
      );
      assign rk[g] = rkeys[g][rk_idx[g]];
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse (x^254) then the affine map.
   task automatic build_sbox();
      logic [7:0] y;
      for (int v = 0; v < 256; v++) begin
         y = 8'h01;
         for (int k = 0; k < 254; k++) y = gmul(y, 8'(v));
         sb_t[v] = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^
                   {y[3:0], y[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
   endfunction

   // Key bytes are 00, 01, 02, ... for every key size.
   task automatic key_expand(input int g);
      int          nk, nr;
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      nk = 4 + 2 * g;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         rkeys[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
      end
   endtask

   function automatic logic [127:0] aes_ref(input int g, input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] ct;
      int           nr;
      nr = 10 + 2 * g;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkeys[g][0][127-8*i -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
         for (int c = 0; c < 4; c++) begin
            if (rd < nr) begin
               s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
               s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
            end else begin
               for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkeys[g][rd][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      return ct;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic sb_push(input int g, input logic [127:0] v);
      case (g)
         0:       sbq0.push_back(v);
         1:       sbq1.push_back(v);
         default: sbq2.push_back(v);
      endcase
   endtask

   function automatic int sb_size(input int g);
      case (g)
         0:       return sbq0.size();
         1:       return sbq1.size();
         default: return sbq2.size();
      endcase
   endfunction

   task automatic sb_pop(input int g, input logic [127:0] act);
      logic [127:0] e;
      int           sz;
      sz = sb_size(g);
      if (sz == 0) begin
         check($sformatf("k%0d_spurious_output", g), 128'(sz), 128'd1);
         return;
      end
      case (g)
         0:       e = sbq0.pop_front();
         1:       e = sbq1.pop_front();
         default: e = sbq2.pop_front();
      endcase
      check($sformatf("k%0d_ciphertext", g), act, e);
   endtask

   // Monitor: compare on each output handshake; while core 0 is back-pressured, its output
   // must keep showing the oldest outstanding ciphertext.
   always @(negedge clk) begin
      if (hold_pend) begin
         check("hold_valid", 128'(out_valid[0]), 128'd1);
         if (sbq0.size() != 0) check("hold_data", text_out[0], sbq0[0]);
      end
      hold_pend <= rst && out_valid[0] && !out_ready[0];
      if (rst) begin
         for (int g = 0; g < NDUT; g++) begin
            if (out_valid[g] && out_ready[g]) sb_pop(g, text_out[g]);
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at posedge+1 with the core idle and out_ready high.
   task automatic run_vec(input int g, input logic [127:0] pt, input logic [127:0] exp);
      int nr, lat;
      nr  = 10 + 2 * g;
      lat = 0;
      check($sformatf("k%0d_idle_rk_idx", g), 128'(rk_idx[g]), 128'd0);
      check($sformatf("k%0d_idle_in_ready", g), 128'(in_ready[g]), 128'd1);
      in_valid[g] = 1'b1;
      text_in[g]  = pt;
      sb_push(g, exp);
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
      text_in[g]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      check($sformatf("k%0d_busy_run", g), 128'(busy[g]), 128'd1);
      while (!out_valid[g] && lat < 40) begin
         if (lat < nr) check($sformatf("k%0d_rk_idx_%0d", g, lat + 1), 128'(rk_idx[g]), 128'(lat + 1));
`ifdef AES_ENC_DBG_EN
         if (g == 0) begin
            if (lat < nr - 1) check("dbg_round", 128'(dbg_round[0]), 128'(lat + 1));
            if (lat == 1) check("dbg_state_r1", dbg_state[0], R1_C1);
         end
`endif
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("k%0d_latency", g), 128'(lat), 128'(nr));
      check($sformatf("k%0d_busy_done", g), 128'(busy[g]), 128'd0);
`ifdef AES_ENC_DBG_EN
      if (g == 0) check("dbg_round_idle", 128'(dbg_round[0]), 128'd0);
`endif
      @(posedge clk); #1;
   endtask

   task automatic send(input int g, input logic [127:0] pt, input logic [127:0] exp);
      int n;
      n = 0;
      while (!in_ready[g] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready[g]) begin
         check($sformatf("k%0d_send_timeout", g), 128'(in_ready[g]), 128'd1);
         return;
      end
      in_valid[g] = 1'b1;
      text_in[g]  = pt;
      sb_push(g, exp);
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
      text_in[g]  = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   initial begin
      logic [127:0] pa, pb, ea, eb;
      int           n;
      for (int g = 0; g < NDUT; g++) begin
         in_valid[g]  = 1'b0;
         text_in[g]   = '0;
         out_ready[g] = 1'b1;
      end
      build_sbox();
      for (int g = 0; g < NDUT; g++) key_expand(g);

      // Reset state
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(in_ready[0]), 128'd0);
      check("rst_out_valid", 128'(out_valid[0]), 128'd0);
      check("rst_text_out", text_out[0], 128'd0);
      check("rst_busy", 128'(busy[0]), 128'd0);
      check("rst_rk_idx", 128'(rk_idx[0]), 128'd0);
      rst = 1'b1;
      #1;
      check("rel_in_ready", 128'(in_ready[0]), 128'd1);

      // Known-answer vectors for all three key sizes
      run_vec(0, PT, CT128);
      run_vec(1, PT, CT192);
      run_vec(2, PT, CT256);

      // Back-pressure: two blocks with the consumer stalled
      pa = {$urandom(), $urandom(), $urandom(), $urandom()};
      pb = {$urandom(), $urandom(), $urandom(), $urandom()};
      ea = aes_ref(0, pa);
      eb = aes_ref(0, pb);
      out_ready[0] = 1'b0;
      send(0, pa, ea);
      send(0, pb, eb);
      repeat (14) @(posedge clk);
      #1;
      check("bp_stall_rk_idx", 128'(rk_idx[0]), 128'd10);
      check("bp_stall_busy", 128'(busy[0]), 128'd1);
      check("bp_stall_in_ready", 128'(in_ready[0]), 128'd0);
      check("bp_first_held", text_out[0], ea);
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      check("bp_ov_stays", 128'(out_valid[0]), 128'd1);
      check("bp_busy_clear", 128'(busy[0]), 128'd0);
      check("bp_second", text_out[0], eb);
      repeat (3) @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("bp_ov_clear", 128'(out_valid[0]), 128'd0);

      // Reset in the middle of round 5 discards the block
      in_valid[0] = 1'b1;
      text_in[0]  = PT;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      n = 0;
      while (rk_idx[0] != 4'd5 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_round5", 128'(rk_idx[0]), 128'd5);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
      check("mid_rst_busy", 128'(busy[0]), 128'd0);
      check("mid_rst_rk_idx", 128'(rk_idx[0]), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready[0]), 128'd0);
      rst = 1'b1;
      #1;
      check("mid_rel_in_ready", 128'(in_ready[0]), 128'd1);
      repeat (12) @(posedge clk);
      #1;
      check("mid_no_output", 128'(out_valid[0]), 128'd0);
      run_vec(0, PT, CT128);

      repeat (4) @(posedge clk);
      #1;
      for (int g = 0; g < NDUT; g++) begin
         check($sformatf("k%0d_sb_drained", g), 128'(sb_size(g)), 128'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
